// File: rtl/layer1_weight_loader_pkg.sv
// Shared constants and state types for the Layer 1 weight/bias loader.
// Row geometry derives from the Layer 1 node count and weight width.
package layer1_weight_loader_pkg;
  localparam int RELU_NODES        = 16;
  localparam int LAYER_1_BIT_WIDTH = 8;
  localparam int LAYER_1_INPUTS    = 784;
  localparam int LOADER_BEAT_WIDTH = 32;
  localparam int LOADER_ADDR_W     = 10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_IDLE = 3'd1,
    S_COLLECT   = 3'd2,
    S_WRITE     = 3'd3,
    S_DONE      = 3'd4
  } load_state_t;

  typedef enum logic {
    PH_WEIGHT = 1'b0,
    PH_BIAS   = 1'b1
  } load_phase_t;
endpackage

// File: rtl/layer1_weight_loader_row_assembler.sv
// Packs WORD_W/BEAT_W host beats into one row, beat 0 in the LSBs; o_last flags that
// the next accepted beat completes the row. Clear drops any partial row.
module layer1_weight_loader_row_assembler #(
  parameter int WORD_W = 128,
  parameter int BEAT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_accept,
  input  logic [BEAT_W-1:0] i_beat,
  output logic [WORD_W-1:0] o_word,
  output logic              o_last
);
  localparam int BEATS = WORD_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_word;
  logic              w_last;

  assign w_last = (r_cnt == CNT_W'(BEATS - 1));
  assign o_last = w_last;
  assign o_word = r_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_accept) begin
      for (int k = 0; k < BEATS; k++) begin
        if (r_cnt == CNT_W'(k)) r_word[k*BEAT_W +: BEAT_W] <= i_beat;
      end
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/layer1_weight_loader.sv
// Loads NUM_ROWS Layer 1 weight rows then one bias row from a host beat stream,
// one write strobe per row (BEATS+1 cycles per row), holding off inference while busy.
module layer1_weight_loader
  import layer1_weight_loader_pkg::*;
#(
  parameter int NUM_ROWS = LAYER_1_INPUTS,
  parameter int WORD_W   = RELU_NODES * LAYER_1_BIT_WIDTH,
  parameter int BEAT_W   = LOADER_BEAT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     loadStart,
  input  logic                     abort,
  input  logic                     pipelineIdle,
  input  logic                     beatValid,
  input  logic [BEAT_W-1:0]        beatData,
  output logic                     beatReady,
  output logic                     loadBusy,
  output logic                     loadDone,
  output logic                     loadError,
  output logic                     weightWriteEnable,
  output logic                     biasWriteEnable,
  output logic [LOADER_ADDR_W-1:0] WriteAddressSelect,
  output logic [WORD_W-1:0]        writeIn
);
  load_state_t              r_state, w_state_nxt;
  load_phase_t              r_phase, w_phase_nxt;
  logic [LOADER_ADDR_W-1:0] r_row, w_row_nxt;
  logic [LOADER_ADDR_W-1:0] r_addr, w_addr_nxt;
  logic r_ready, w_ready_nxt;
  logic r_busy, w_busy_nxt;
  logic r_done, w_done_nxt;
  logic r_error, w_error_nxt;
  logic r_wwe, w_wwe_nxt;
  logic r_bwe, w_bwe_nxt;
  logic w_clear, w_accept, w_last;
  logic [WORD_W-1:0] w_word;

  assign w_accept = beatValid && r_ready;

  layer1_weight_loader_row_assembler #(.WORD_W(WORD_W), .BEAT_W(BEAT_W)) u_row_assembler (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_accept (w_accept),
    .i_beat   (beatData),
    .o_word   (w_word),
    .o_last   (w_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_row_nxt   = r_row;
    w_addr_nxt  = r_addr;
    w_ready_nxt = r_ready;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_error_nxt = r_error;
    w_wwe_nxt   = 1'b0;
    w_bwe_nxt   = 1'b0;
    w_clear     = 1'b0;
    if (abort && (r_state == S_WAIT_IDLE || r_state == S_COLLECT || r_state == S_WRITE)) begin
      w_state_nxt = S_IDLE;
      w_ready_nxt = 1'b0;
      w_busy_nxt  = 1'b0;
      w_error_nxt = 1'b1;
      w_clear     = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: if (loadStart && !abort) begin
          w_state_nxt = S_WAIT_IDLE;
          w_busy_nxt  = 1'b1;
          w_error_nxt = 1'b0;
          w_phase_nxt = PH_WEIGHT;
          w_row_nxt   = '0;
        end
        S_WAIT_IDLE: if (pipelineIdle) begin
          w_state_nxt = S_COLLECT;
          w_ready_nxt = 1'b1;
          w_clear     = 1'b1;
        end
        S_COLLECT: if (w_accept && w_last) begin
          w_state_nxt = S_WRITE;
          w_ready_nxt = 1'b0;
          w_wwe_nxt   = (r_phase == PH_WEIGHT);
          w_bwe_nxt   = (r_phase == PH_BIAS);
          w_addr_nxt  = (r_phase == PH_WEIGHT) ? r_row : '0;
        end
        S_WRITE: if (r_phase == PH_BIAS) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_COLLECT;
          w_ready_nxt = 1'b1;
          if (r_row == LOADER_ADDR_W'(NUM_ROWS - 1)) w_phase_nxt = PH_BIAS;
          else                                       w_row_nxt   = r_row + LOADER_ADDR_W'(1);
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_phase <= PH_WEIGHT;
      r_row   <= '0;
      r_addr  <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_wwe   <= 1'b0;
      r_bwe   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_row   <= w_row_nxt;
      r_addr  <= w_addr_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_error <= w_error_nxt;
      r_wwe   <= w_wwe_nxt;
      r_bwe   <= w_bwe_nxt;
    end
  end

  // Strobes are only high in WRITE; an abort landing there must keep storage untouched.
  assign weightWriteEnable  = r_wwe & ~abort;
  assign biasWriteEnable    = r_bwe & ~abort;
  assign beatReady          = r_ready;
  assign loadBusy           = r_busy;
  assign loadDone           = r_done;
  assign loadError          = r_error;
  assign WriteAddressSelect = r_addr;
  assign writeIn            = w_word;
endmodule

// File: tb/tb_layer1_weight_loader.sv
// Randomized bench for layer1_weight_loader: a row-packing scoreboard built from the
// accepted beat stream predicts every strobe, address, row value and the done pulse.
module tb_layer1_weight_loader;
  localparam int NUM_ROWS = 784;
  localparam int BEAT_W   = 32;
  localparam int WORD_W   = 128;
  localparam int BEATS    = WORD_W / BEAT_W;

  logic clk = 1'b0;
  logic reset, loadStart, abort, pipelineIdle, beatValid;
  logic [BEAT_W-1:0] beatData;
  logic beatReady, loadBusy, loadDone, loadError, weightWriteEnable, biasWriteEnable;
  logic [9:0] WriteAddressSelect;
  logic [WORD_W-1:0] writeIn;

  always #5 clk = ~clk;

  layer1_weight_loader dut (
    .clk(clk), .reset(reset), .loadStart(loadStart), .abort(abort),
    .pipelineIdle(pipelineIdle), .beatValid(beatValid), .beatData(beatData),
    .beatReady(beatReady), .loadBusy(loadBusy), .loadDone(loadDone), .loadError(loadError),
    .weightWriteEnable(weightWriteEnable), .biasWriteEnable(biasWriteEnable),
    .WriteAddressSelect(WriteAddressSelect), .writeIn(writeIn)
  );

  int n_checks = 0, n_errs = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: every BEATS accepted beats of an active load form the next row.
  logic [BEAT_W-1:0] m_beats [BEATS];
  int m_k, m_row;
  bit m_active, due, due_bias, done_due, ready_due, last_acc, gap_row5;
  logic [WORD_W-1:0] exp_word;
  logic [9:0] exp_addr;
  int cyc, done_cyc, n_done, n_w, n_b;
  int i, w0, b0, start_cyc;

  task automatic drive_beat();
    if (!beatValid || last_acc) begin
      beatValid = (gap_row5 && m_row == 5) ? 1'($urandom_range(0, 1)) : 1'b1;
      beatData  = {16'(m_row), 8'(m_k), 8'($urandom_range(0, 255))};
    end
  endtask

  task automatic tick();
    logic [1:0] strobe;
    bit acc;
    drive_beat();
    @(negedge clk);
    cyc++;
    strobe = {weightWriteEnable, biasWriteEnable};
    if (weightWriteEnable) n_w++;
    if (biasWriteEnable) n_b++;
    if (ready_due) check("ready_after_write", beatReady, 1);
    if (done_due) begin
      check("done_pulse", loadDone, 1);
      check("busy_in_done", loadBusy, 1);
      check("ready_in_done", beatReady, 0);
      n_done++;
      done_cyc = cyc;
      m_active = 0;
    end else check("no_done", loadDone, 0);
    ready_due = 0;
    done_due  = 0;
    if (due && !abort) begin
      check("strobe_kind", strobe, due_bias ? 2'b01 : 2'b10);
      check("strobe_addr", WriteAddressSelect, exp_addr);
      check("strobe_data", writeIn, exp_word);
      if (due_bias) done_due = 1; else ready_due = 1;
    end else check("no_strobe", strobe, 2'b00);
    due = 0;
    acc = beatValid && beatReady;
    last_acc = acc;
    if (!m_active) check("accept_outside_load", acc, 0);
    else if (abort) begin
      m_active = 0;
      m_k = 0;
    end else if (acc) begin
      m_beats[m_k] = beatData;
      m_k++;
      if (m_k == BEATS) begin
        for (int k = 0; k < BEATS; k++) exp_word[k*BEAT_W +: BEAT_W] = m_beats[k];
        due_bias = (m_row == NUM_ROWS);
        exp_addr = due_bias ? 10'd0 : 10'(m_row);
        due = 1;
        m_k = 0;
        m_row++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    m_active = 1; m_row = 0; m_k = 0;
    loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int n0, j;
    n0 = n_done;
    j = 0;
    while (n_done == n0 && j < budget) begin
      tick();
      j++;
    end
    check(tag, 32'(n_done - n0), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, beatReady, 0);
    check({tag, "_busy"}, loadBusy, 0);
    check({tag, "_done"}, loadDone, 0);
    check({tag, "_error"}, loadError, 0);
    check({tag, "_wwe"}, weightWriteEnable, 0);
    check({tag, "_bwe"}, biasWriteEnable, 0);
    check({tag, "_addr"}, WriteAddressSelect, 0);
    check({tag, "_data"}, writeIn, 0);
  endtask

  initial begin
    reset = 1'b0; loadStart = 1'b0; abort = 1'b0; pipelineIdle = 1'b1;
    beatValid = 1'b0; beatData = '0; gap_row5 = 0;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) tick();

    // Abort after two beats of row 10, then abort+loadStart together in IDLE.
    w0 = n_w;
    start_load();
    check("t4_busy_start", loadBusy, 1);
    i = 0;
    while (!(m_row == 10 && m_k == 2) && i < 2000) begin tick(); i++; end
    check("t4_reach_row10", (m_row == 10 && m_k == 2), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_error", loadError, 1);
    check("t4_busy", loadBusy, 0);
    check("t4_ready", beatReady, 0);
    repeat (10) tick();
    check("t4_rows_written", 32'(n_w - w0), 32'd10);
    check("t4_error_sticky", loadError, 1);
    abort = 1'b1; loadStart = 1'b1;
    tick();
    abort = 1'b0; loadStart = 1'b0;
    repeat (3) tick();
    check("t6_abort_start_busy", loadBusy, 0);
    check("t6_abort_start_error", loadError, 1);

    // Full load with beatValid always high; restart clears loadError.
    w0 = n_w; b0 = n_b;
    start_load();
    start_cyc = cyc;
    check("t1_error_cleared", loadError, 0);
    check("t1_busy", loadBusy, 1);
    run_until_done(5000, "t1_done");
    check("t1_done_cycle", 32'(done_cyc - (start_cyc + 1)), 32'(785 * 5 + 1));
    check("t1_weight_strobes", 32'(n_w - w0), 32'd784);
    check("t1_bias_strobes", 32'(n_b - b0), 32'd1);
    check("t1_busy_after", loadBusy, 0);

    // pipelineIdle held low 20 cycles, gaps on row 5, stray loadStart mid-load.
    w0 = n_w; b0 = n_b;
    pipelineIdle = 1'b0;
    start_load();
    for (int c = 0; c < 20; c++) begin
      check("t3_busy_wait", loadBusy, 1);
      check("t3_ready_wait", beatReady, 0);
      tick();
    end
    pipelineIdle = 1'b1;
    check("t3_ready_rise_cycle", beatReady, 0);
    tick();
    check("t3_ready_collect", beatReady, 1);
    gap_row5 = 1;
    i = 0;
    while (m_row < 200 && i < 3000) begin tick(); i++; end
    loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
    run_until_done(8000, "t2_done");
    check("t2_weight_strobes", 32'(n_w - w0), 32'd784);
    check("t2_bias_strobes", 32'(n_b - b0), 32'd1);
    check("t2_error", loadError, 0);
    gap_row5 = 0;

    // Asynchronous reset during the WRITE cycle of row 0.
    start_load();
    i = 0;
    while (!due && i < 100) begin tick(); i++; end
    @(negedge clk);
    check("t5_write_strobe", weightWriteEnable, 1);
    #1 reset = 1'b0;
    #1;
    check_all_zero("t5_reset");
    due = 0; ready_due = 0; done_due = 0; m_active = 0; m_k = 0; last_acc = 0;
    @(posedge clk); #1;
    w0 = n_w;
    repeat (5) tick();
    check("t5_no_strobe_in_reset", 32'(n_w - w0), 32'd0);
    reset = 1'b1;
    w0 = n_w;
    start_load();
    check("t5_restart_busy", loadBusy, 1);
    repeat (17) tick();
    check("t5_restart_rows", 32'(n_w - w0), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
